// File: rtl/dff_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dff_share_arbiter
// Purpose  : Round-robin arbiter sharing one WIDTH-bit D register among NREQ
//            requesters. At most one requester is granted per cycle and its
//            data is captured at the same edge. A requester asserting lock
//            together with req keeps ownership for up to MAX_HOLD consecutive
//            writes, after which it is released so others cannot starve.
// Ports    : clk      - clock, rising edge
//            rst_n    - asynchronous active-low reset
//            req      - per-requester write request      [NREQ]
//            lock     - per-requester hold request       [NREQ]
//            wdata    - packed write data, requester i at [i*WIDTH +: WIDTH]
//            gnt      - registered one-hot grant for the previous edge
//            q        - shared register contents
//            q_owner  - id of the requester that last wrote q
//            q_valid  - set by the first write after reset
// Revision : 1.0 - initial release
// ============================================================================
module dff_share_arbiter #(
  parameter int  NREQ     = 4,
  parameter int  WIDTH    = 8,
  parameter int  MAX_HOLD = 8,
  localparam int IDW      = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       lock,
  input  logic [NREQ*WIDTH-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      q,
  output logic [IDW-1:0]        q_owner,
  output logic                  q_valid
);

  // hold_cnt never exceeds MAX_HOLD, so it needs enough bits to hold MAX_HOLD.
  localparam int             c_hold_w  = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [IDW-1:0] c_last_id = IDW'(NREQ - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_OWNED = 1'b1
  } state_t;

  state_t                r_state;
  logic [NREQ-1:0]       r_gnt;
  logic [WIDTH-1:0]      r_q;
  logic [IDW-1:0]        r_owner;
  logic                  r_valid;
  logic [IDW-1:0]        r_rr_ptr;
  logic [c_hold_w-1:0]   r_hold_cnt;

  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  logic [IDW-1:0]        w_next_ptr;
  logic [IDW-1:0]        w_sel;
  logic                  w_sel_req;
  logic                  w_sel_lock;
  logic [WIDTH-1:0]      w_sel_data;
  logic [NREQ-1:0]       w_sel_onehot;
  logic [c_hold_w-1:0]   w_hold_inc;
  logic                  w_hold_last;

  // Round-robin pick: requesters at or above rr_ptr outrank those below it,
  // and within each group the lowest index wins. The second loop runs last,
  // so any hit at or above the pointer overrides a wrapped-around hit.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) < r_rr_ptr)) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (IDW'(i) >= r_rr_ptr)) begin
        w_found  = 1'b1;
        w_winner = IDW'(i);
      end
    end
  end

  assign w_next_ptr = (w_winner == c_last_id) ? '0 : w_winner + IDW'(1);

  // While owned, only the owner is considered; otherwise the arbitration
  // winner. One mux serves data, req, lock and the one-hot grant.
  always_comb begin
    w_sel        = (r_state == S_OWNED) ? r_owner : w_winner;
    w_sel_req    = 1'b0;
    w_sel_lock   = 1'b0;
    w_sel_data   = '0;
    w_sel_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == w_sel) begin
        w_sel_req       = req[i];
        w_sel_lock      = lock[i];
        w_sel_data      = wdata[i*WIDTH +: WIDTH];
        w_sel_onehot[i] = 1'b1;
      end
    end
  end

  assign w_hold_inc  = r_hold_cnt + c_hold_w'(1);
  assign w_hold_last = (w_hold_inc == c_hold_w'(MAX_HOLD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_gnt      <= '0;
      r_q        <= '0;
      r_owner    <= '0;
      r_valid    <= 1'b0;
      r_rr_ptr   <= '0;
      r_hold_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_q      <= w_sel_data;
            r_owner  <= w_winner;
            r_valid  <= 1'b1;
            r_gnt    <= w_sel_onehot;
            // Pointer is fixed at owner+1 for the whole ownership period.
            r_rr_ptr <= w_next_ptr;
            if (w_sel_lock && (MAX_HOLD > 1)) begin
              r_state    <= S_OWNED;
              r_hold_cnt <= c_hold_w'(1);
            end
          end else begin
            r_gnt <= '0;
          end
        end

        S_OWNED: begin
          if (w_sel_req) begin
            r_q        <= w_sel_data;
            r_gnt      <= w_sel_onehot;
            r_hold_cnt <= w_hold_inc;
            // Dropping lock makes this the last write; reaching the hold
            // limit forces release regardless of lock.
            if (!w_sel_lock || w_hold_last) begin
              r_state <= S_IDLE;
            end
          end else begin
            r_gnt   <= '0;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign q       = r_q;
  assign q_owner = r_owner;
  assign q_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dff_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_share_arbiter
// Purpose  : Self-checking bench for dff_share_arbiter (NREQ=4, WIDTH=8,
//            MAX_HOLD=4). Directed scenarios followed by random traffic, all
//            compared against a behavioural ownership/rotation model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_share_arbiter;

  localparam int NREQ     = 4;
  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [WIDTH-1:0]      wd [NREQ];
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      q;
  logic [1:0]            q_owner;
  logic                  q_valid;

  assign wdata = {wd[3], wd[2], wd[1], wd[0]};

  always #5 clk = ~clk;

  dff_share_arbiter #(
    .NREQ     (NREQ),
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .lock    (lock),
    .wdata   (wdata),
    .gnt     (gnt),
    .q       (q),
    .q_owner (q_owner),
    .q_valid (q_valid)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: ownership flag, writes made in this ownership,
  // rotation start point, and the visible outputs.
  bit         m_own;
  int         m_owner;
  int         m_writes;
  int         m_ptr;
  logic [7:0] m_q;
  logic       m_valid;
  logic [3:0] m_gnt;

  task automatic model_reset();
    m_own = 0; m_owner = 0; m_writes = 0; m_ptr = 0;
    m_q = 8'h00; m_valid = 1'b0; m_gnt = 4'b0000;
  endtask

  task automatic model_edge();
    int w;
    w = -1;
    if (m_own) begin
      if (req[m_owner]) w = m_owner;
      else m_own = 0;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        int i;
        i = (m_ptr + k) % NREQ;
        if (w < 0 && req[i]) w = i;
      end
    end
    if (w < 0) begin
      m_gnt = 4'b0000;
    end else begin
      m_gnt   = 4'(1 << w);
      m_q     = wd[w];
      m_owner = w;
      m_valid = 1'b1;
      if (m_own) begin
        m_writes++;
        if (!lock[w] || m_writes == MAX_HOLD) m_own = 0;
      end else begin
        m_ptr = (w + 1) % NREQ;
        if (lock[w] && MAX_HOLD > 1) begin
          m_own = 1; m_writes = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_gnt"},   32'(gnt),     32'(m_gnt));
    chk({tag, "_q"},     32'(q),       32'(m_q));
    chk({tag, "_owner"}, 32'(q_owner), 32'(m_owner));
    chk({tag, "_valid"}, 32'(q_valid), 32'(m_valid));
  endtask

  // Inputs are set by the caller at posedge+1; the model advances, the
  // edge occurs, and outputs are sampled 1 time unit later.
  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Reset asserted mid-cycle, released 1 unit after the following edge.
  task automatic hard_reset();
    rst_n = 1'b0;
    #2;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  logic [3:0] exp_gnt [5];
  logic [7:0] exp_q   [5];

  initial begin
    // Reset held with every requester active.
    rst_n = 1'b0;
    req   = 4'b1111;
    lock  = 4'b0000;
    wd    = '{8'h11, 8'h22, 8'h33, 8'h44};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt",   32'(gnt),     32'h0);
    chk("rst_q",     32'(q),       32'h0);
    chk("rst_valid", 32'(q_valid), 32'h0);
    chk("rst_owner", 32'(q_owner), 32'h0);
    rst_n = 1'b1;
    req   = 4'b0000;
    step("idle");

    // Single request.
    req   = 4'b0010;
    wd[1] = 8'hA5;
    step("single");
    chk("single_q",     32'(q),       32'hA5);
    chk("single_owner", 32'(q_owner), 32'h1);
    chk("single_gnt",   32'(gnt),     32'h2);
    req = 4'b0000;
    step("single_after");
    chk("single_gnt_drop", 32'(gnt), 32'h0);

    // Asynchronous reset mid-cycle clears outputs before the next edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_q",     32'(q),       32'h0);
    chk("async_valid", 32'(q_valid), 32'h0);
    chk("async_owner", 32'(q_owner), 32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Fairness: rotation 0,1,2,3,0 with all requesters active.
    req = 4'b1111;
    wd  = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_q   = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    for (int i = 0; i < 5; i++) begin
      step("fair");
      chk("fair_gnt", 32'(gnt), 32'(exp_gnt[i]));
      chk("fair_q",   32'(q),   32'(exp_q[i]));
    end

    // Lock for two writes, release on the third, then requester 2.
    hard_reset();
    req  = 4'b0101;
    lock = 4'b0001;
    wd   = '{8'h20, 8'h21, 8'h22, 8'h23};
    step("lk1");
    chk("lk1_gnt", 32'(gnt), 32'h1);
    wd[0] = 8'h24;
    step("lk2");
    chk("lk2_gnt", 32'(gnt), 32'h1);
    lock  = 4'b0000;
    wd[0] = 8'h25;
    step("lk3");
    chk("lk3_gnt", 32'(gnt), 32'h1);
    chk("lk3_q",   32'(q),   32'h25);
    req = 4'b0100;
    step("lk4");
    chk("lk4_gnt", 32'(gnt), 32'h4);
    chk("lk4_q",   32'(q),   32'h22);

    // Forced release after MAX_HOLD writes.
    hard_reset();
    req  = 4'b0011;
    lock = 4'b0001;
    wd   = '{8'h30, 8'h31, 8'h32, 8'h33};
    for (int i = 0; i < MAX_HOLD; i++) begin
      step("force_hold");
      chk("force_hold_gnt",   32'(gnt),     32'h1);
      chk("force_hold_owner", 32'(q_owner), 32'h0);
    end
    step("force_rel");
    chk("force_rel_gnt",   32'(gnt),     32'h2);
    chk("force_rel_owner", 32'(q_owner), 32'h1);

    // Reset during ownership, then arbitration restarts at requester 0.
    hard_reset();
    req  = 4'b0001;
    lock = 4'b0001;
    step("own_rst1");
    #2;
    rst_n = 1'b0;
    #1;
    chk("own_rst_q",     32'(q),       32'h0);
    chk("own_rst_valid", 32'(q_valid), 32'h0);
    chk("own_rst_gnt",   32'(gnt),     32'h0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req   = 4'b1111;
    lock  = 4'b0000;
    step("own_rst_after");
    chk("own_rst_after_gnt", 32'(gnt), 32'h1);

    // Random traffic with lock biased high to exercise ownership.
    for (int n = 0; n < 400; n++) begin
      req  = 4'($urandom);
      lock = 4'($urandom) | 4'($urandom);
      for (int i = 0; i < NREQ; i++) wd[i] = 8'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        hard_reset();
      end else begin
        step("rnd");
        chk("rnd_onehot", 32'($onehot0(gnt)), 32'h1);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
